// File: rtl/bft_out_scheduler.sv
`timescale 1ns/1ps
// Round-robin scheduler that funnels several HLS ap_vld/ap_ack output streams into one
// BFT output slot, tagging each payload with its configured destination and sequence number.
module bft_out_scheduler #(
  parameter int unsigned NUM_OUT_PORTS = 3,
  parameter int unsigned PAYLOAD_BITS  = 32,
  parameter int unsigned NUM_LEAF_BITS = 4,
  parameter int unsigned NUM_PORT_BITS = 4,
  parameter int unsigned NUM_ADDR_BITS = 7,
  parameter int unsigned PACKET_BITS   = 2 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS
                                         + PAYLOAD_BITS,
  parameter int unsigned INIT_CREDIT   = 64
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic                                    enable_i,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_user_i,
  input  logic [NUM_OUT_PORTS-1:0]                vld_user_i,
  output logic [NUM_OUT_PORTS-1:0]                ack_user_o,
  input  logic                                    cfg_wr_i,
  input  logic [NUM_PORT_BITS-1:0]                cfg_sel_i,
  input  logic [NUM_LEAF_BITS-1:0]                cfg_leaf_i,
  input  logic [NUM_PORT_BITS-1:0]                cfg_port_i,
  input  logic                                    credit_vld_i,
  input  logic [NUM_PORT_BITS-1:0]                credit_sel_i,
  input  logic [7:0]                              credit_amt_i,
  output logic [PACKET_BITS-1:0]                  dout_pkt_o,
  input  logic                                    bft_ready_i
);

  localparam int unsigned PtrW = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;

  logic [NUM_OUT_PORTS-1:0] tbl_vld_q;
  logic [NUM_LEAF_BITS-1:0] tbl_leaf_q [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] tbl_port_q [NUM_OUT_PORTS];
  logic [7:0]               credit_q   [NUM_OUT_PORTS];
  logic [7:0]               credit_d   [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] seq_q      [NUM_OUT_PORTS];
  logic [PtrW-1:0]          rr_q, rr_d;
  logic [PACKET_BITS-1:0]   pkt_q, pkt_d;

  logic                     slot_free;
  logic [NUM_OUT_PORTS-1:0] eligible;
  logic                     grant_vld;
  logic [PtrW-1:0]          grant_idx;
  logic [PAYLOAD_BITS-1:0]  grant_payload;

  // The slot's valid bit doubles as the EMPTY/FULL state.
  assign slot_free = ~pkt_q[PACKET_BITS-1] | bft_ready_i;

  always_comb begin
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      eligible[i] = enable_i & vld_user_i[i] & tbl_vld_q[i] & (credit_q[i] != 8'd0);
    end
  end

  // First eligible port at or after the pointer, searching upward with wrap.
  always_comb begin
    logic [PtrW-1:0] idx;
    idx       = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NUM_OUT_PORTS; k++) begin
      idx = PtrW'((32'(rr_q) + k) % NUM_OUT_PORTS);
      if (!grant_vld && eligible[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
    if (!slot_free) begin
      grant_vld = 1'b0;
    end
  end

  always_comb begin
    ack_user_o    = '0;
    grant_payload = '0;
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      if (grant_vld && grant_idx == PtrW'(i)) begin
        ack_user_o[i] = 1'b1;
        grant_payload = din_user_i[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  always_comb begin
    if (grant_vld) begin
      pkt_d = {1'b1, 1'b0, tbl_leaf_q[grant_idx], tbl_port_q[grant_idx], seq_q[grant_idx],
               grant_payload};
    end else if (slot_free) begin
      pkt_d = '0;
    end else begin
      pkt_d = pkt_q;
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (grant_vld) begin
      rr_d = (32'(grant_idx) == NUM_OUT_PORTS - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  // Return and grant on the same port net out before saturation.
  always_comb begin
    logic [9:0] sum;
    sum = '0;
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      sum = {2'b00, credit_q[i]};
      if (credit_vld_i && credit_sel_i == NUM_PORT_BITS'(i)) begin
        sum = sum + {2'b00, credit_amt_i};
      end
      if (grant_vld && grant_idx == PtrW'(i)) begin
        sum = sum - 10'd1;
      end
      if (sum > 10'(INIT_CREDIT)) begin
        sum = 10'(INIT_CREDIT);
      end
      credit_d[i] = sum[7:0];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pkt_q     <= '0;
      rr_q      <= '0;
      tbl_vld_q <= '0;
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
        tbl_leaf_q[i] <= '0;
        tbl_port_q[i] <= '0;
        credit_q[i]   <= 8'(INIT_CREDIT);
        seq_q[i]      <= '0;
      end
    end else begin
      pkt_q <= pkt_d;
      rr_q  <= rr_d;
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_q[i] <= credit_d[i];
        if (grant_vld && grant_idx == PtrW'(i)) begin
          seq_q[i] <= seq_q[i] + 1'b1;
        end
        if (cfg_wr_i && cfg_sel_i == NUM_PORT_BITS'(i)) begin
          tbl_vld_q[i]  <= 1'b1;
          tbl_leaf_q[i] <= cfg_leaf_i;
          tbl_port_q[i] <= cfg_port_i;
        end
      end
    end
  end

  assign dout_pkt_o = pkt_q;

endmodule

// File: tb/tb_bft_out_scheduler.sv
`timescale 1ns/1ps
// Directed self-checking bench for bft_out_scheduler: arbitration order, backpressure,
// credits, same-cycle config/credit interaction, enable, sequence wrap and async reset.
module tb_bft_out_scheduler;

  localparam int N   = 3;
  localparam int PKB = 49;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic [N*32-1:0] din_user;
  logic [N-1:0]    vld_user;
  logic [N-1:0]    ack_user;
  logic            cfg_wr;
  logic [3:0]      cfg_sel, cfg_leaf, cfg_port;
  logic            credit_vld;
  logic [3:0]      credit_sel;
  logic [7:0]      credit_amt;
  logic [PKB-1:0]  dout_pkt;
  logic            bft_ready;

  int n_assert = 0;
  int n_fail   = 0;
  int cnt;
  logic [6:0]     exp_s;
  logic [PKB-1:0] held;

  bft_out_scheduler dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .enable_i     (enable),
    .din_user_i   (din_user),
    .vld_user_i   (vld_user),
    .ack_user_o   (ack_user),
    .cfg_wr_i     (cfg_wr),
    .cfg_sel_i    (cfg_sel),
    .cfg_leaf_i   (cfg_leaf),
    .cfg_port_i   (cfg_port),
    .credit_vld_i (credit_vld),
    .credit_sel_i (credit_sel),
    .credit_amt_i (credit_amt),
    .dout_pkt_o   (dout_pkt),
    .bft_ready_i  (bft_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [PKB-1:0] mkpkt(input logic [3:0] leaf, input logic [3:0] port,
                                           input logic [6:0] seq, input logic [31:0] pay);
    return {1'b1, 1'b0, leaf, port, seq, pay};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] sel, input logic [3:0] leaf, input logic [3:0] port);
    cfg_wr = 1'b1; cfg_sel = sel; cfg_leaf = leaf; cfg_port = port;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic credit_ret(input logic [3:0] sel, input logic [7:0] amt);
    credit_vld = 1'b1; credit_sel = sel; credit_amt = amt;
    tick();
    credit_vld = 1'b0;
  endtask

  // Counts acks on one port over a fixed number of cycles with the given request mask.
  task automatic count_acks(input logic [N-1:0] mask, input int bit_i, input int cycles,
                            output int n);
    n = 0;
    vld_user = mask;
    for (int c = 0; c < cycles; c++) begin
      #1;
      if (ack_user[bit_i]) n++;
      tick();
    end
    vld_user = '0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; din_user = '0; vld_user = '0; cfg_wr = 1'b0;
    cfg_sel = '0; cfg_leaf = '0; cfg_port = '0; credit_vld = 1'b0; credit_sel = '0;
    credit_amt = '0; bft_ready = 1'b0;
    #2;
    chk("reset_dout", 64'(dout_pkt), 64'd0);
    chk("reset_ack", 64'(ack_user), 64'd0);
    tick();
    tick();
    reset = 1'b0;

    // Nothing configured: requests are never acked.
    enable = 1'b1; bft_ready = 1'b1; vld_user = 3'b111;
    #1 chk("unconfigured_ack", 64'(ack_user), 64'd0);
    tick();
    chk("unconfigured_dout", 64'(dout_pkt), 64'd0);
    vld_user = '0;
    cfg_write(4'd0, 4'd2, 4'd1);
    cfg_write(4'd1, 4'd5, 4'd3);
    vld_user = 3'b100;
    #1 chk("invalid_entry_ack", 64'(ack_user), 64'd0);
    tick();
    vld_user = '0;
    cfg_write(4'd2, 4'd9, 4'd0);

    // Round robin with all three requesting.
    din_user = {32'hC000_0002, 32'hB000_0001, 32'hA000_0000};
    vld_user = 3'b111;
    #1 chk("rr_ack0", 64'(ack_user), 64'b001);
    tick(); chk("rr_pkt0", 64'(dout_pkt), 64'(mkpkt(4'd2, 4'd1, 7'd0, 32'hA000_0000)));
    #1 chk("rr_ack1", 64'(ack_user), 64'b010);
    tick(); chk("rr_pkt1", 64'(dout_pkt), 64'(mkpkt(4'd5, 4'd3, 7'd0, 32'hB000_0001)));
    #1 chk("rr_ack2", 64'(ack_user), 64'b100);
    tick(); chk("rr_pkt2", 64'(dout_pkt), 64'(mkpkt(4'd9, 4'd0, 7'd0, 32'hC000_0002)));
    #1 chk("rr_ack3", 64'(ack_user), 64'b001);
    tick(); chk("rr_pkt3", 64'(dout_pkt), 64'(mkpkt(4'd2, 4'd1, 7'd1, 32'hA000_0000)));
    vld_user = '0;
    #1 chk("rr_idle_ack", 64'(ack_user), 64'd0);
    tick(); chk("rr_drain_empty", 64'(dout_pkt), 64'd0);

    // Backpressure on port1.
    bft_ready = 1'b0; vld_user = 3'b010; din_user[63:32] = 32'hB111_0001;
    #1 chk("bp_first_ack", 64'(ack_user), 64'b010);
    tick();
    held = mkpkt(4'd5, 4'd3, 7'd1, 32'hB111_0001);
    chk("bp_pkt", 64'(dout_pkt), 64'(held));
    din_user[63:32] = 32'hD000_0001;
    for (int c = 0; c < 5; c++) begin
      #1 chk("bp_hold_ack", 64'(ack_user), 64'd0);
      tick(); chk("bp_hold_pkt", 64'(dout_pkt), 64'(held));
    end
    bft_ready = 1'b1;
    #1 chk("bp_release_ack", 64'(ack_user), 64'b010);
    tick(); chk("bp_next_pkt", 64'(dout_pkt), 64'(mkpkt(4'd5, 4'd3, 7'd2, 32'hD000_0001)));
    vld_user = '0;
    tick(); chk("bp_empty", 64'(dout_pkt), 64'd0);

    // Credit exhaustion and saturation on port0 (62 left -> top up to 64).
    credit_ret(4'd0, 8'd100);
    count_acks(3'b001, 0, 70, cnt);
    chk("credit_exhaust_cnt", 64'(cnt), 64'd64);
    credit_ret(4'd0, 8'd1);
    count_acks(3'b001, 0, 5, cnt);
    chk("credit_one_cnt", 64'(cnt), 64'd1);
    credit_ret(4'd0, 8'd100);
    credit_ret(4'd0, 8'd100);
    count_acks(3'b001, 0, 70, cnt);
    chk("credit_sat_cnt", 64'(cnt), 64'd64);

    // Bring port2 down to one credit, then grant + return + reconfigure in one cycle.
    count_acks(3'b100, 2, 62, cnt);
    chk("p2_drain_cnt", 64'(cnt), 64'd62);
    din_user[95:64] = 32'hE000_0002;
    vld_user = 3'b100;
    credit_vld = 1'b1; credit_sel = 4'd2; credit_amt = 8'd3;
    cfg_wr = 1'b1; cfg_sel = 4'd2; cfg_leaf = 4'd7; cfg_port = 4'd6;
    #1 chk("combo_ack", 64'(ack_user), 64'b100);
    tick();
    credit_vld = 1'b0; cfg_wr = 1'b0;
    chk("combo_old_leaf", 64'(dout_pkt), 64'(mkpkt(4'd9, 4'd0, 7'd63, 32'hE000_0002)));
    #1 chk("combo_next_ack", 64'(ack_user), 64'b100);
    tick(); chk("combo_new_leaf", 64'(dout_pkt), 64'(mkpkt(4'd7, 4'd6, 7'd64, 32'hE000_0002)));
    count_acks(3'b100, 2, 4, cnt);
    chk("combo_credit_cnt", 64'(cnt), 64'd2);

    // Out-of-range indices must not alias onto real ports.
    credit_ret(4'd6, 8'd5);
    cfg_write(4'd4, 4'hF, 4'hF);
    count_acks(3'b100, 2, 3, cnt);
    chk("oor_credit_cnt", 64'(cnt), 64'd0);

    // Enable dropped with a packet stuck in the slot.
    credit_ret(4'd0, 8'd100);
    bft_ready = 1'b0; vld_user = 3'b011; din_user[31:0] = 32'h1234_5678;
    #1 chk("en_first_ack", 64'(ack_user), 64'b001);
    tick();
    held = mkpkt(4'd2, 4'd1, 7'd3, 32'h1234_5678);
    chk("en_pkt_oor_cfg", 64'(dout_pkt), 64'(held));
    enable = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1 chk("en_off_ack", 64'(ack_user), 64'd0);
      tick(); chk("en_off_hold", 64'(dout_pkt), 64'(held));
    end
    bft_ready = 1'b1;
    #1 chk("en_off_drain_ack", 64'(ack_user), 64'd0);
    tick(); chk("en_off_drain", 64'(dout_pkt), 64'd0);
    #1 chk("en_off_idle_ack", 64'(ack_user), 64'd0);
    tick();
    enable = 1'b1; vld_user = '0;

    // Sequence wrap on port0 with a steady one-credit return.
    exp_s = 7'd4;
    vld_user = 3'b001;
    credit_vld = 1'b1; credit_sel = 4'd0; credit_amt = 8'd1;
    for (int i = 0; i < 126; i++) begin
      din_user[31:0] = 32'(i);
      #1 chk("wrap_ack", 64'(ack_user), 64'b001);
      tick(); chk("wrap_pkt", 64'(dout_pkt), 64'(mkpkt(4'd2, 4'd1, exp_s, 32'(i))));
      exp_s = exp_s + 7'd1;
    end
    chk("wrap_last_seq", 64'(dout_pkt[38:32]), 64'd1);

    // Asynchronous reset with the slot full.
    #2 reset = 1'b1;
    #1 chk("async_rst_dout", 64'(dout_pkt), 64'd0);
    chk("async_rst_ack", 64'(ack_user), 64'd0);
    tick();
    reset = 1'b0; credit_vld = 1'b0;
    vld_user = 3'b111;
    #1 chk("post_rst_ack", 64'(ack_user), 64'd0);
    tick(); chk("post_rst_dout", 64'(dout_pkt), 64'd0);
    vld_user = '0;
    cfg_write(4'd0, 4'd3, 4'd2);
    vld_user = 3'b001; din_user[31:0] = 32'hCAFE_0000;
    #1 chk("post_rst_grant", 64'(ack_user), 64'b001);
    tick(); chk("post_rst_seq0", 64'(dout_pkt), 64'(mkpkt(4'd3, 4'd2, 7'd0, 32'hCAFE_0000)));
    vld_user = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bft_out_scheduler.md
Name: bft_out_scheduler

Overview:
- Shares one BFT output slot among NUM_OUT_PORTS user output streams.
- User streams are HLS ap_vld/ap_ack streams with 32-bit payloads.
- Each cycle, a round-robin arbiter picks an eligible stream, looks up its configured destination (leaf, port) and wraps the payload into a packet.
- Per-port credit counters enforce destination freespace; the block sits between user kernel outputs and the leaf-to-BFT output register.

Parameters:
NUM_OUT_PORTS, 3, number of user output streams (1..8)
PAYLOAD_BITS, 32, user payload width
NUM_LEAF_BITS, 4, destination leaf field width
NUM_PORT_BITS, 4, destination port field width
NUM_ADDR_BITS, 7, sequence-number width
PACKET_BITS, 49, equals 2+NUM_LEAF_BITS+NUM_PORT_BITS+NUM_ADDR_BITS+PAYLOAD_BITS
INIT_CREDIT, 64, credits per port after reset (max 255)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
enable  in  1  arbitration enable
din_user  in  NUM_OUT_PORTS*PAYLOAD_BITS  payloads; port i at slice i
vld_user  in  NUM_OUT_PORTS  per-port valid
ack_user  out  NUM_OUT_PORTS  per-port ack (one-hot or zero)
cfg_wr  in  1  destination-table write strobe
cfg_sel  in  NUM_PORT_BITS  table index
cfg_leaf  in  NUM_LEAF_BITS  destination leaf
cfg_port  in  NUM_PORT_BITS  destination port
credit_vld  in  1  credit return strobe
credit_sel  in  NUM_PORT_BITS  port receiving credit
credit_amt  in  8  credits returned
dout_pkt  out  PACKET_BITS  packet; MSB = valid
bft_ready  in  1  downstream accepts dout_pkt this cycle

Behaviour:
- Reset (async, immediate):
  - dout_pkt=0, ack_user=0.
  - RR pointer=0, all credits=INIT_CREDIT, all sequence counters=0.
  - All table entries invalid, leaf/port fields=0.
- Packet format, MSB first: valid(1), type(1, always 0 = data), dst_leaf, dst_port, seq, payload.
- Output slot:
  - Held in a single register, EMPTY or FULL.
  - The slot is "free" when EMPTY, or when FULL and bft_ready=1.
- Port i is eligible when all hold: enable=1, vld_user[i]=1, table[i] valid, credit[i]>0.
- Grant (combinational):
  - If the slot is free and any port is eligible, grant the first eligible port at or after the RR pointer, searching upward with wrap.
  - ack_user[grant]=1; all other acks are 0.
  - ack is never asserted while the slot is FULL and bft_ready=0.
- On the clock edge with a grant:
  - dout_pkt <= {1, 0, table[g].leaf, table[g].port, seq[g], payload g}.
  - seq[g] increments, wrapping 2^NUM_ADDR_BITS-1 -> 0.
  - credit[g] decrements.
  - RR pointer <= g+1 (wraps to 0 after NUM_OUT_PORTS-1).
- Latency: vld+ack at edge k puts the packet on dout_pkt from k+1.
- Throughput: with bft_ready held high, one packet per cycle (back-to-back).
- On an edge with the slot FULL, bft_ready=1 and no grant: dout_pkt <= 0 (EMPTY).
- While FULL and bft_ready=0: dout_pkt is held unchanged.
- Credits:
  - credit_vld adds credit_amt to credit[credit_sel], saturating at INIT_CREDIT.
  - A return and a grant on the same port in the same cycle give credit + amt - 1, saturated at INIT_CREDIT.
- Config:
  - cfg_wr writes leaf/port and sets the valid bit for entry cfg_sel.
  - A grant in the same cycle uses the pre-write entry; the new value applies from the next cycle.
- Out-of-range indices: cfg_sel or credit_sel >= NUM_OUT_PORTS are ignored with no state change.
- enable=0: no new grants; a FULL packet still drains on bft_ready.
- Reset during a FULL slot: the packet is discarded, no ack is issued, and state returns to reset values.

Test Plan:
- Reset check: after reset, table[0..2] = (leaf 2, port 1), (5, 3), (9, 0); drive vld_user=3'b111, bft_ready=1 -> acks in order port0, port1, port2, port0 on consecutive cycles; dout_pkt valid every cycle with seq 0,0,0,1.
- Backpressure: single requester port1, bft_ready=0 for 5 cycles -> exactly one ack; dout_pkt stable with dst_leaf=5, dst_port=3. Raise bft_ready -> next ack in the same cycle; no payload lost or duplicated.
- Credit exhaustion: port0 only, INIT_CREDIT=64 -> 64 acks, then none. Return credit_amt=1 -> exactly one more ack. Return of 100 on a full counter -> credit stays 64.
- Same-cycle grant plus credit return to port2 with credit=1 and amt=3 -> credit becomes 3. Simultaneous cfg_wr to port2 -> the current packet carries the old leaf, the next packet the new leaf.
- Unconfigured port or enable=0: vld on an invalid entry -> never acked. Dropping enable mid-stream -> in-flight packet drains and no new acks.
- Sequence wrap: 130 packets on port0 with credits replenished -> seq field goes 127 then 0 then 1. Assert reset mid-stream -> dout_pkt=0 immediately, asynchronously.
